led_color_decode: RTL and testbench

Measures the three PWM LED drive lines (red, green, blue) over a fixed sampling window and decodes them back into the 2-bit RYGB color code that produced them. It sits on the receive side of the LED color interface, downstream of the color encoder and its 12 %/25 % PWM generators. It serves as a self-check monitor and as a loopback decoder in lab builds. Per-channel high-time counters feed a two-state measure/evaluate controller that emits one classification per window.

---
 rtl/led_color_decode.sv | 175 +++++++++++++++++
 tb/tb_led_color_decode.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_color_decode.sv
// rtl/led_color_decode.sv - decode red/green/blue PWM lines back into a 2-bit color code
//
// Purpose:
//   Counts the high samples on each LED drive line over a fixed window of
//   WINDOW clk cycles. At the end of each window the three totals are
//   classified as red, yellow, green or blue. A window that matches none of
//   these colors is reported as an error.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   led_r        red PWM line
//   led_g        green PWM line
//   led_b        blue PWM line
//   color        decoded code (0 red, 1 yellow, 2 green, 3 blue), held on error
//   color_valid  one-cycle pulse when a window decodes to a legal color
//   color_err    one-cycle pulse when a window matches no color
//
// Optional build macro:
//   LED_DECODE_SYNC_EN - 2-flop synchronizer on each LED input
module led_color_decode #(
  parameter int WINDOW  = 100,
  parameter int DUTY_HI = 25,
  parameter int DUTY_LO = 12,
  parameter int TOL     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_r,
  input  logic       led_g,
  input  logic       led_b,
  output logic [1:0] color,
  output logic       color_valid,
  output logic       color_err
);

  localparam int CW   = $clog2(WINDOW + 1);
  localparam int E_HI = WINDOW * DUTY_HI / 100;
  localparam int E_LO = WINDOW * DUTY_LO / 100;

  localparam logic [CW-1:0] E_HI_C = CW'(E_HI);
  localparam logic [CW-1:0] E_LO_C = CW'(E_LO);
  localparam logic [CW-1:0] TOL_C  = CW'(TOL);
  localparam logic [CW-1:0] LAST_C = CW'(WINDOW - 1);

  typedef enum logic {MEAS, EVAL} state_t;

  // Samples seen by the counters, ordered {r, g, b}
  logic [2:0] smp;

`ifdef LED_DECODE_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {led_r, led_g, led_b};
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q;
`else
  assign smp = {led_r, led_g, led_b};
`endif

  logic [CW-1:0] win_cnt_q;
  logic [CW-1:0] cnt_r_q, cnt_g_q, cnt_b_q;
  logic [CW-1:0] tot_r_q, tot_g_q, tot_b_q;
  logic          last;

  state_t     state_q, state_d;
  logic [1:0] color_q, color_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  assign last = (win_cnt_q == LAST_C);

  // Counting never pauses, not even during EVAL, so window boundaries stay
  // locked to reset release. The last sample of a window goes into the
  // total directly while the running counters restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
      cnt_r_q   <= '0;
      cnt_g_q   <= '0;
      cnt_b_q   <= '0;
      tot_r_q   <= '0;
      tot_g_q   <= '0;
      tot_b_q   <= '0;
    end else if (last) begin
      win_cnt_q <= '0;
      tot_r_q   <= cnt_r_q + CW'(smp[2]);
      tot_g_q   <= cnt_g_q + CW'(smp[1]);
      tot_b_q   <= cnt_b_q + CW'(smp[0]);
      cnt_r_q   <= '0;
      cnt_g_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + CW'(1);
      cnt_r_q   <= cnt_r_q + CW'(smp[2]);
      cnt_g_q   <= cnt_g_q + CW'(smp[1]);
      cnt_b_q   <= cnt_b_q + CW'(smp[0]);
    end
  end

  // Compare first, then subtract, so the unsigned difference never wraps
  function automatic logic near(input logic [CW-1:0] x, input logic [CW-1:0] e);
    if (x >= e) return ((x - e) <= TOL_C);
    else        return ((e - x) <= TOL_C);
  endfunction

  function automatic logic off(input logic [CW-1:0] x);
    return (x <= TOL_C);
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MEAS;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEAS:    if (last) state_d = EVAL;
      EVAL:    state_d = MEAS;
      default: state_d = MEAS;
    endcase
  end

  // FSM outputs: classify the latched totals during EVAL, in priority order
  always_comb begin
    color_d = color_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == EVAL) begin
      if (near(tot_r_q, E_HI_C) && off(tot_g_q) && off(tot_b_q)) begin
        color_d = 2'd0;
        valid_d = 1'b1;
      end else if (near(tot_r_q, E_LO_C) && near(tot_g_q, E_LO_C) && off(tot_b_q)) begin
        color_d = 2'd1;
        valid_d = 1'b1;
      end else if (off(tot_r_q) && near(tot_g_q, E_HI_C) && off(tot_b_q)) begin
        color_d = 2'd2;
        valid_d = 1'b1;
      end else if (off(tot_r_q) && off(tot_g_q) && near(tot_b_q, E_HI_C)) begin
        color_d = 2'd3;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q <= 2'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      color_q <= color_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign color       = color_q;
  assign color_valid = valid_q;
  assign color_err   = err_q;

endmodule

// File: tb/tb_led_color_decode.sv
// tb/tb_led_color_decode.sv - self-checking bench for led_color_decode
module tb_led_color_decode;

  localparam int W    = 100;
  localparam int E_HI = 25;
  localparam int E_LO = 12;
  localparam int TOL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led_r = 1'b0, led_g = 1'b0, led_b = 1'b0;
  logic [1:0] color;
  logic       color_valid, color_err;

  led_color_decode dut (
    .clk         (clk),
    .rst         (rst),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .color       (color),
    .color_valid (color_valid),
    .color_err   (color_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit e;
  } exp_t;

  typedef struct {
    int hr, hg, hb, off;
    int c;
    bit e;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecount = 0;
  bit   mon_en = 1'b0;
  int   exp_color = 0;
  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference classification straight from the color rules
  function automatic void ref_classify(input int r, input int g, input int b,
                                       output int c, output bit e);
    bit on_r = absd(r, E_HI) <= TOL, on_g = absd(g, E_HI) <= TOL, on_b = absd(b, E_HI) <= TOL;
    bit lo_r = absd(r, E_LO) <= TOL, lo_g = absd(g, E_LO) <= TOL;
    bit dk_r = r <= TOL, dk_g = g <= TOL, dk_b = b <= TOL;
    e = 1'b0;
    c = 0;
    if      (on_r && dk_g && dk_b) c = 0;
    else if (lo_r && lo_g && dk_b) c = 1;
    else if (dk_r && on_g && dk_b) c = 2;
    else if (dk_r && dk_g && on_b) c = 3;
    else e = 1'b1;
  endfunction

  // Edges since reset release
  always @(posedge clk) begin
    if (rst) ecount = 0;
    else     ecount = ecount + 1;
  end

  // Result of window k must appear exactly at edge kW+W+1 and nowhere else
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ecount > W && (ecount % W) == 1) begin
        check("result_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t x;
          x = q.pop_front();
          check("color_valid", int'(color_valid), int'(!x.e));
          check("color_err", int'(color_err), int'(x.e));
          if (!x.e) exp_color = x.c;
          check("color", int'(color), exp_color);
        end
      end else begin
        check("no_pulse", int'({color_valid, color_err}), 0);
        check("color_hold", int'(color), exp_color);
      end
      check("pulse_exclusive", int'(color_valid && color_err), 0);
    end
  end

  // Drive one window of contiguous PWM pulses; the model counts what was driven
  task automatic drive_window(input int hr, input int hg, input int hb, input int off,
                              input bit use_exp, input int ec, input bit ee);
    int tr = 0, tg = 0, tb = 0;
    int ph;
    exp_t x;
    for (int p = 0; p < W; p++) begin
      ph = (p - off + W) % W;
      led_r = (ph < hr);
      led_g = (ph < hg);
      led_b = (ph < hb);
      tr += int'(led_r);
      tg += int'(led_g);
      tb += int'(led_b);
      @(negedge clk);
    end
    if (use_exp) begin
      x.c = ec;
      x.e = ee;
    end else begin
      ref_classify(tr, tg, tb, x.c, x.e);
    end
    q.push_back(x);
  endtask

  vec_t vecs[18];
  int   vals[20] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 14, 15, 22, 23, 24, 25, 26, 27, 28, 50, 100};

  initial begin
    vecs[0]  = '{25, 0, 0, 0, 0, 1'b0};     // red
    vecs[1]  = '{25, 0, 0, 0, 0, 1'b0};     // red repeated
    vecs[2]  = '{25, 0, 0, 37, 0, 1'b0};    // red with phase shift
    vecs[3]  = '{12, 12, 0, 5, 1, 1'b0};    // yellow
    vecs[4]  = '{0, 25, 0, 0, 2, 1'b0};     // green
    vecs[5]  = '{0, 0, 27, 0, 3, 1'b0};     // blue at upper tolerance
    vecs[6]  = '{0, 0, 28, 0, 0, 1'b1};     // blue just outside
    vecs[7]  = '{0, 0, 0, 0, 0, 1'b1};      // all dark
    vecs[8]  = '{100, 100, 100, 0, 0, 1'b1};// all on
    vecs[9]  = '{23, 0, 0, 90, 0, 1'b0};    // red at lower tolerance
    vecs[10] = '{22, 0, 0, 0, 0, 1'b1};     // red just outside
    vecs[11] = '{25, 2, 0, 50, 0, 1'b0};    // stray green at off limit
    vecs[12] = '{25, 3, 0, 0, 0, 1'b1};     // stray green over off limit
    vecs[13] = '{14, 10, 0, 0, 1, 1'b0};    // yellow at both tolerance edges
    vecs[14] = '{15, 12, 0, 0, 0, 1'b1};    // yellow red too high
    vecs[15] = '{0, 27, 2, 0, 2, 1'b0};     // green edges
    vecs[16] = '{2, 2, 23, 77, 3, 1'b0};    // blue edges
    vecs[17] = '{12, 12, 3, 0, 0, 1'b1};    // yellow with blue leak

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_color", int'(color), 0);
    check("reset_valid", int'(color_valid), 0);
    check("reset_err", int'(color_err), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 18; i++)
      drive_window(vecs[i].hr, vecs[i].hg, vecs[i].hb, vecs[i].off, 1'b1, vecs[i].c, vecs[i].e);

    // Randomized windows against the reference model
    for (int i = 0; i < 24; i++)
      drive_window(vals[$urandom_range(0, 19)], vals[$urandom_range(0, 19)],
                   vals[$urandom_range(0, 19)], $urandom_range(0, W - 1), 1'b0, 0, 1'b0);

    // Blue window so color is 3, then reset in the middle of a red window
    drive_window(0, 0, 25, 0, 1'b1, 3, 1'b0);
    for (int p = 0; p < 50; p++) begin
      led_r = (p < 25);
      led_g = 1'b0;
      led_b = 1'b0;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    q.delete();
    exp_color = 0;
    #1;
    check("async_reset_color", int'(color), 0);
    check("async_reset_valid", int'(color_valid), 0);
    check("async_reset_err", int'(color_err), 0);
    led_r = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("held_reset_color", int'(color), 0);
      check("held_reset_pulses", int'({color_valid, color_err}), 0);
    end
    rst = 1'b0;
    drive_window(0, 0, 25, 0, 1'b1, 3, 1'b0);
    drive_window(0, 0, 25, 13, 1'b1, 3, 1'b0);

    led_r = 1'b0;
    led_g = 1'b0;
    led_b = 1'b0;
    repeat (3) @(negedge clk);
    check("all_results_seen", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
